// File: rtl/decoder.sv
// -----------------------------------------------------------------------------
// decoder
// Turns a stream of token IDs back into text. Token IDs are read from a token
// SRAM, each ID k>=1 is resolved to the k-th zero-terminated word of the vocab
// SRAM, and the word bytes are written to an output SRAM. The text is closed
// with a 0 terminator. All three SRAMs read synchronously with 1-cycle latency.
//
// Build option:
//   DECODER_SEP_EN  when defined, SEP is written between consecutive words;
//                   when undefined, words are simply concatenated.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cs              start pulse, honoured in IDLE and DONE
//   done            high from entry to DONE until the next start
//   err             sticky per run: unresolvable token or output overflow
//   tok_addr/dout   token SRAM read port
//   voc_addr/dout   vocab SRAM read port
//   out_addr/din/we output SRAM write port (one byte per cycle)
//
// Vocabulary resolution: cnt starts at k-1 and is decremented on every 0 byte
// of the vocab scan; the copy starts where cnt reaches 0. Empty slots (a 0 at
// the start of a word, e.g. zero padding after the last real word) are not
// words: the copy skips them, and a token that only finds padding up to
// VOCAB_END is flagged and dropped without writing anything.
//
// Read-latency bookkeeping: in SEEK and COPY the scan address advances every
// cycle, so voc_dout always holds the byte at voc_addr_q-1 (after the first
// priming cycle of SEEK).
// -----------------------------------------------------------------------------
module decoder #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] VOCAB_END  = {ADDR_WIDTH{1'b1}},
    parameter logic [DATA_WIDTH-1:0] SEP        = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_dout,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_we
);

`ifdef DECODER_SEP_EN
    localparam logic SEP_EN = 1'b1;
`else
    localparam logic SEP_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] A_TOP  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] D_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TOK_RD  = 3'd1,
        S_TOK_CHK = 3'd2,
        S_SEEK    = 3'd3,
        S_COPY    = 3'd4,
        S_NEXT    = 3'd5,
        S_TERM    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   tok_addr_q, tok_addr_d;
    logic [ADDR_WIDTH-1:0]   voc_addr_q, voc_addr_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [ADDR_WIDTH-1:0]   wptr_q,     wptr_d;     // next free output address
    logic [DATA_WIDTH-1:0]   out_din_q,  out_din_d;
    logic [DATA_WIDTH-1:0]   tok_id_q,   tok_id_d;
    logic [DATA_WIDTH-1:0]   cnt_q,      cnt_d;
    logic                    out_we_q,   out_we_d;
    logic                    done_q,     done_d;
    logic                    err_q,      err_d;
    logic                    vld_q,      vld_d;      // voc_dout valid in SEEK
    logic                    first_q,    first_d;    // COPY at start of a word
    logic                    word_wr_q,  word_wr_d;  // a word byte was written
    logic [DATA_WIDTH-1:0]   cnt_dec_s;

    assign done     = done_q;
    assign err      = err_q;
    assign tok_addr = tok_addr_q;
    assign voc_addr = voc_addr_q;
    assign out_addr = out_addr_q;
    assign out_din  = out_din_q;
    assign out_we   = out_we_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tok_addr_q <= A_ZERO;
            voc_addr_q <= A_ZERO;
            out_addr_q <= A_ZERO;
            wptr_q     <= A_ZERO;
            out_din_q  <= D_ZERO;
            tok_id_q   <= D_ZERO;
            cnt_q      <= D_ZERO;
            out_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            word_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tok_addr_q <= tok_addr_d;
            voc_addr_q <= voc_addr_d;
            out_addr_q <= out_addr_d;
            wptr_q     <= wptr_d;
            out_din_q  <= out_din_d;
            tok_id_q   <= tok_id_d;
            cnt_q      <= cnt_d;
            out_we_q   <= out_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            word_wr_q  <= word_wr_d;
        end
    end

    // Word counter after accounting for a terminator seen this cycle
    always_comb begin
        cnt_dec_s = cnt_q;
        if (voc_dout == D_ZERO) begin
            cnt_dec_s = cnt_q - D_ONE;
        end else begin
            cnt_dec_s = cnt_q;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        tok_addr_d = tok_addr_q;
        voc_addr_d = voc_addr_q;
        out_addr_d = out_addr_q;
        wptr_d     = wptr_q;
        out_din_d  = out_din_q;
        tok_id_d   = tok_id_q;
        cnt_d      = cnt_q;
        out_we_d   = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        vld_d      = vld_q;
        first_d    = first_q;
        word_wr_d  = word_wr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cs) begin
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    tok_addr_d = A_ZERO;
                    out_addr_d = A_ZERO;
                    wptr_d     = A_ZERO;
                    word_wr_d  = 1'b0;
                    state_d    = S_TOK_RD;
                end else begin
                    state_d = state_q;
                end
            end
            S_TOK_RD: begin
                state_d = S_TOK_CHK;
            end
            S_TOK_CHK: begin
                tok_id_d = tok_dout;
                if (tok_dout == D_ZERO) begin
                    state_d = S_TERM;
                end else if (SEP_EN && word_wr_q && (wptr_q == A_TOP)) begin
                    // the separator would take the terminator slot
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else begin
                    if (SEP_EN && word_wr_q) begin
                        out_we_d   = 1'b1;
                        out_din_d  = SEP;
                        out_addr_d = wptr_q;
                        wptr_d     = wptr_q + A_ONE;
                    end else begin
                        out_we_d = 1'b0;
                    end
                    voc_addr_d = A_ZERO;
                    cnt_d      = tok_dout - D_ONE;
                    vld_d      = 1'b0;
                    state_d    = S_SEEK;
                end
            end
            S_SEEK: begin
                if (!vld_q) begin
                    // priming cycle: the read of voc_addr_q is still in flight
                    voc_addr_d = voc_addr_q + A_ONE;
                    if (tok_id_q == D_ONE) begin
                        first_d = 1'b1;
                        state_d = S_COPY;
                    end else begin
                        vld_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_dec_s;
                    if (voc_addr_q == VOCAB_END) begin
                        err_d   = 1'b1;
                        state_d = S_NEXT;
                    end else if (cnt_dec_s == D_ZERO) begin
                        voc_addr_d = voc_addr_q + A_ONE;
                        first_d    = 1'b1;
                        state_d    = S_COPY;
                    end else begin
                        voc_addr_d = voc_addr_q + A_ONE;
                    end
                end
            end
            S_COPY: begin
                if (voc_dout != D_ZERO) begin
                    if (wptr_q == A_TOP) begin
                        err_d   = 1'b1;
                        state_d = S_TERM;
                    end else begin
                        out_we_d   = 1'b1;
                        out_din_d  = voc_dout;
                        out_addr_d = wptr_q;
                        wptr_d     = wptr_q + A_ONE;
                        word_wr_d  = 1'b1;
                        first_d    = 1'b0;
                        if (voc_addr_q == VOCAB_END) begin
                            // word runs off the vocab without a terminator
                            err_d   = 1'b1;
                            state_d = S_NEXT;
                        end else begin
                            voc_addr_d = voc_addr_q + A_ONE;
                        end
                    end
                end else if (!first_q) begin
                    state_d = S_NEXT;
                end else if (voc_addr_q == VOCAB_END) begin
                    // only padding up to the end of the vocab: token unresolved
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    voc_addr_d = voc_addr_q + A_ONE;
                end
            end
            S_NEXT: begin
                if (tok_addr_q == A_TOP) begin
                    state_d = S_TERM;
                end else begin
                    tok_addr_d = tok_addr_q + A_ONE;
                    state_d    = S_TOK_RD;
                end
            end
            S_TERM: begin
                out_we_d   = 1'b1;
                out_din_d  = D_ZERO;
                out_addr_d = wptr_q;
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
